// File: rtl/ysyx_24100006_pipe_pkg.sv
// Shared definitions for the EXE/MEM pipeline bundle.
//   - Field widths and LSB offsets of the 164-bit packed bundle (MSB->LSB:
//     pc, alu_result, store_data, csr_wdata, Csr_Write_Addr, Gpr_Write_Addr,
//     Gpr_Write_RD, Mem_WMask, Mem_RMask, Gpr_Write, Csr_Write,
//     sram_read_write, is_break, is_fence_i).
//   - exe_mem_t struct plus pack/unpack helpers between struct and vector.
package ysyx_24100006_pipe_pkg;

  localparam int PKG_XLEN        = 32;

  localparam int W_PC            = 32;
  localparam int W_ALU_RESULT    = 32;
  localparam int W_STORE_DATA    = 32;
  localparam int W_CSR_WDATA     = 32;
  localparam int W_CSR_WADDR     = 12;
  localparam int W_GPR_WADDR     = 4;
  localparam int W_GPR_WRD       = 3;
  localparam int W_MEM_WMASK     = 8;
  localparam int W_MEM_RMASK     = 3;
  localparam int W_SRAM_RW       = 2;

  // LSB offsets, built from the bottom field upward
  localparam int OFF_IS_FENCE_I  = 0;
  localparam int OFF_IS_BREAK    = OFF_IS_FENCE_I + 1;
  localparam int OFF_SRAM_RW     = OFF_IS_BREAK + 1;
  localparam int OFF_CSR_WRITE   = OFF_SRAM_RW + W_SRAM_RW;
  localparam int OFF_GPR_WRITE   = OFF_CSR_WRITE + 1;
  localparam int OFF_MEM_RMASK   = OFF_GPR_WRITE + 1;
  localparam int OFF_MEM_WMASK   = OFF_MEM_RMASK + W_MEM_RMASK;
  localparam int OFF_GPR_WRD     = OFF_MEM_WMASK + W_MEM_WMASK;
  localparam int OFF_GPR_WADDR   = OFF_GPR_WRD + W_GPR_WRD;
  localparam int OFF_CSR_WADDR   = OFF_GPR_WADDR + W_GPR_WADDR;
  localparam int OFF_CSR_WDATA   = OFF_CSR_WADDR + W_CSR_WADDR;
  localparam int OFF_STORE_DATA  = OFF_CSR_WDATA + W_CSR_WDATA;
  localparam int OFF_ALU_RESULT  = OFF_STORE_DATA + W_STORE_DATA;
  localparam int OFF_PC          = OFF_ALU_RESULT + W_ALU_RESULT;

  localparam int PKG_PAYLOAD_W   = OFF_PC + W_PC;  // 164

  typedef struct packed {
    logic [W_PC-1:0]         pc;
    logic [W_ALU_RESULT-1:0] alu_result;
    logic [W_STORE_DATA-1:0] store_data;
    logic [W_CSR_WDATA-1:0]  csr_wdata;
    logic [W_CSR_WADDR-1:0]  csr_write_addr;
    logic [W_GPR_WADDR-1:0]  gpr_write_addr;
    logic [W_GPR_WRD-1:0]    gpr_write_rd;
    logic [W_MEM_WMASK-1:0]  mem_wmask;
    logic [W_MEM_RMASK-1:0]  mem_rmask;
    logic                    gpr_write;
    logic                    csr_write;
    logic [W_SRAM_RW-1:0]    sram_read_write;
    logic                    is_break;
    logic                    is_fence_i;
  } exe_mem_t;

  function automatic logic [PKG_PAYLOAD_W-1:0] pack_exe_mem(input exe_mem_t s);
    logic [PKG_PAYLOAD_W-1:0] p;
    p = '0;
    p[OFF_PC         +: W_PC]         = s.pc;
    p[OFF_ALU_RESULT +: W_ALU_RESULT] = s.alu_result;
    p[OFF_STORE_DATA +: W_STORE_DATA] = s.store_data;
    p[OFF_CSR_WDATA  +: W_CSR_WDATA]  = s.csr_wdata;
    p[OFF_CSR_WADDR  +: W_CSR_WADDR]  = s.csr_write_addr;
    p[OFF_GPR_WADDR  +: W_GPR_WADDR]  = s.gpr_write_addr;
    p[OFF_GPR_WRD    +: W_GPR_WRD]    = s.gpr_write_rd;
    p[OFF_MEM_WMASK  +: W_MEM_WMASK]  = s.mem_wmask;
    p[OFF_MEM_RMASK  +: W_MEM_RMASK]  = s.mem_rmask;
    p[OFF_GPR_WRITE]                  = s.gpr_write;
    p[OFF_CSR_WRITE]                  = s.csr_write;
    p[OFF_SRAM_RW    +: W_SRAM_RW]    = s.sram_read_write;
    p[OFF_IS_BREAK]                   = s.is_break;
    p[OFF_IS_FENCE_I]                 = s.is_fence_i;
    return p;
  endfunction

  function automatic exe_mem_t unpack_exe_mem(input logic [PKG_PAYLOAD_W-1:0] p);
    exe_mem_t s;
    s.pc              = p[OFF_PC         +: W_PC];
    s.alu_result      = p[OFF_ALU_RESULT +: W_ALU_RESULT];
    s.store_data      = p[OFF_STORE_DATA +: W_STORE_DATA];
    s.csr_wdata       = p[OFF_CSR_WDATA  +: W_CSR_WDATA];
    s.csr_write_addr  = p[OFF_CSR_WADDR  +: W_CSR_WADDR];
    s.gpr_write_addr  = p[OFF_GPR_WADDR  +: W_GPR_WADDR];
    s.gpr_write_rd    = p[OFF_GPR_WRD    +: W_GPR_WRD];
    s.mem_wmask       = p[OFF_MEM_WMASK  +: W_MEM_WMASK];
    s.mem_rmask       = p[OFF_MEM_RMASK  +: W_MEM_RMASK];
    s.gpr_write       = p[OFF_GPR_WRITE];
    s.csr_write       = p[OFF_CSR_WRITE];
    s.sram_read_write = p[OFF_SRAM_RW    +: W_SRAM_RW];
    s.is_break        = p[OFF_IS_BREAK];
    s.is_fence_i      = p[OFF_IS_FENCE_I];
    return s;
  endfunction

endpackage

// File: rtl/ysyx_24100006_skid_buf.sv
// Generic two-entry valid/ready skid buffer with flush.
//   clk, reset (sync, active-high), flush_i : drop both entries
//   in_valid/in_ready/data_i   : upstream; in_ready is a pure flop output
//   out_valid/out_ready/data_o : downstream, driven by the main entry
//   occupancy_o                : held entries, 0..2
// The skid entry only fills when main is held, so it is always younger.
module ysyx_24100006_skid_buf #(
  parameter int W = 164
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_o,
  output logic [1:0]   occupancy_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         acc, drn;

  // in_ready comes only from a flop: out_ready never reaches upstream
  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign data_o      = main_data_q;
  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign acc = in_valid & in_ready;
  assign drn = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      // a same-cycle arrival is dropped; a same-cycle drain already left
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (acc) begin
        main_data_d  = data_i;
        main_valid_d = 1'b1;
      end
    end else if (drn) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_data_d  = data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_data_d  = data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ysyx_24100006_exe_mem.sv
// EXE/MEM pipeline register: EXEU -> LSU, one-entry skid for a registered
// in_ready, redirect flush drops everything held.
//   clk, reset (sync, active-high), flush_i
//   in_valid/in_ready/payload_i    : from EXEU
//   out_valid/out_ready/payload_o  : toward LSU
//   occupancy_o                    : held entries (debug)
// The bundle is opaque here; it is normalised through the package
// pack/unpack so the field layout has a single definition.
module ysyx_24100006_exe_mem
  import ysyx_24100006_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 164
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [1:0]           occupancy_o
);

  // the bundle layout is fixed in the package; refuse mismatched overrides
  if (XLEN != PKG_XLEN || PAYLOAD_W != PKG_PAYLOAD_W) begin : g_bad_params
    $error("exe_mem: XLEN/PAYLOAD_W do not match the package bundle layout");
  end

  exe_mem_t               bundle_in;
  logic [PAYLOAD_W-1:0]   buf_in;

  assign bundle_in = unpack_exe_mem(payload_i);
  assign buf_in    = pack_exe_mem(bundle_in);

  ysyx_24100006_skid_buf #(.W(PAYLOAD_W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_i      (buf_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_o      (payload_o),
    .occupancy_o (occupancy_o)
  );

endmodule

// File: tb/tb_ysyx_24100006_exe_mem.sv
// Scoreboard bench for ysyx_24100006_exe_mem. The reference is a plain
// queue holding at most two bundles: accept when fewer than two are held,
// drain the oldest, flush empties it, reset empties it.
module tb_ysyx_24100006_exe_mem;
  import ysyx_24100006_pipe_pkg::*;

  localparam int PW = 164;

  logic          clk = 1'b0;
  logic          reset, flush_i, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [PW-1:0] payload_i, payload_o;
  logic [1:0]    occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;
  bit zero_pl = 1;
  int n_out   = 0;
  logic [PW-1:0] q[$];

  ysyx_24100006_exe_mem #(.XLEN(32), .PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .payload_i(payload_i),
    .out_valid(out_valid), .out_ready(out_ready), .payload_o(payload_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [31:0] pc);
    exe_mem_t s;
    s.pc              = pc;
    s.alu_result      = $urandom;
    s.store_data      = $urandom;
    s.csr_wdata       = $urandom;
    s.csr_write_addr  = 12'($urandom);
    s.gpr_write_addr  = 4'($urandom);
    s.gpr_write_rd    = 3'($urandom);
    s.mem_wmask       = 8'($urandom);
    s.mem_rmask       = 3'($urandom);
    s.gpr_write       = 1'($urandom);
    s.csr_write       = 1'($urandom);
    s.sram_read_write = 2'($urandom);
    s.is_break        = 1'($urandom);
    s.is_fence_i      = 1'($urandom);
    return pack_exe_mem(s);
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model by the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      bit acc, drn;
      int sz;
      sz = q.size();
      chk("out_valid",   PW'(out_valid),   PW'(sz > 0));
      chk("in_ready",    PW'(in_ready),    PW'(sz < 2));
      chk("occupancy",   PW'(occupancy_o), PW'(sz));
      if (sz > 0)       chk("payload_o", payload_o, q[0]);
      else if (zero_pl) chk("payload_rst", payload_o, '0);
      if (reset) begin
        q.delete();
        zero_pl = 1;
      end else begin
        acc = in_valid && (sz < 2);
        drn = (sz > 0) && out_ready;
        if (drn) begin
          void'(q.pop_front());
          n_out++;
        end
        if (flush_i) q.delete();
        else if (acc) begin
          q.push_back(payload_i);
          zero_pl = 0;
        end
      end
    end
  end

  task automatic step(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = iv;
    payload_i = mk(pc);
    out_ready = ordy;
    flush_i   = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    payload_i = '0;
    @(posedge clk); #1;
    mon_en = 1;
    step(0, 0, 0, 0);            // still in reset: reset-state checks
    reset = 1'b0;

    // single bundle, 1-cycle latency
    step(1, 32'h8000_0000, 1, 0);
    step(0, 0, 1, 0);

    // back-to-back stream of 8
    base = n_out;
    for (int i = 0; i < 8; i++) step(1, 32'h8000_0000 + 32'(4 * i), 1, 0);
    step(0, 0, 1, 0);
    chk("stream_count", PW'(n_out - base), PW'(8));

    // fill both entries, then drain in order
    step(1, 32'h100, 0, 0);
    step(1, 32'h104, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // flush at occupancy 2 together with a new bundle C
    step(1, 32'h100, 0, 0);
    step(1, 32'h104, 0, 0);
    step(1, 32'h200, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // reset while full, then one bundle with 1-cycle latency
    step(1, 32'h300, 0, 0);
    step(1, 32'h304, 0, 0);
    reset = 1'b1;
    step(1, 32'h308, 1, 0);
    reset = 1'b0;
    step(0, 0, 0, 0);
    step(1, 32'h400, 1, 0);
    step(0, 0, 1, 0);

    // randomized traffic with occasional flushes
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("final_empty", PW'(occupancy_o), '0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
